// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: opcode and ALU control
// encodings, FSM state encoding, instruction field positions and the
// decoded-instruction record produced by seq_decode.
package datapath_sequencer_pkg;

    localparam int INSTR_W_DEF    = 12;
    localparam int REG_ADDR_W_DEF = 2;
    localparam int CNT_W_DEF      = 8;

    // Opcodes, instr[11:9]
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // ALU operation select driven to the datapath
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Field LSB positions within a 12-bit instruction word
    localparam int OPC_LSB = 9;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_LSB = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       needs_write;
        logic       is_branch;
        logic       is_halt;
        logic       is_nop;
    } dec_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Bus between the instruction source / datapath and the sequencer.
//   instr, instr_valid, instr_ready : instruction handshake
//   zero_flag                       : ALU zero result from the datapath
//   read_reg_num1/2, write_reg      : register-file addresses
//   alu_control, regwrite           : datapath control
//   branch_taken, halted            : status
//   retired_count                   : retired-instruction counter
// master = source/datapath side, slave = sequencer side.
interface datapath_sequencer_if
    import datapath_sequencer_pkg::*;
#(
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
);
    logic [INSTR_W-1:0]    instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  zero_flag;
    logic [REG_ADDR_W-1:0] read_reg_num1;
    logic [REG_ADDR_W-1:0] read_reg_num2;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [2:0]            alu_control;
    logic                  regwrite;
    logic                  branch_taken;
    logic                  halted;
    logic [CNT_W-1:0]      retired_count;

    modport master (
        output instr, instr_valid, zero_flag,
        input  instr_ready, read_reg_num1, read_reg_num2, write_reg,
               alu_control, regwrite, branch_taken, halted, retired_count
    );

    modport slave (
        input  instr, instr_valid, zero_flag,
        output instr_ready, read_reg_num1, read_reg_num2, write_reg,
               alu_control, regwrite, branch_taken, halted, retired_count
    );
endinterface

// File: rtl/datapath_sequencer_decode.sv
// seq_decode: purely combinational opcode decoder.
//   opcode : instruction opcode field
//   dec    : {alu_control, needs_write, is_branch, is_halt, is_nop}
// NOP and HALT do not use the ALU; they report ADD so alu_control sits at
// its idle value.
module seq_decode
    import datapath_sequencer_pkg::*;
(
    input  logic [2:0] opcode,
    output dec_t       dec
);
    always_comb begin
        dec             = '0;
        dec.alu_control = ALU_ADD;
        case (opcode)
            OP_NOP:  dec.is_nop = 1'b1;
            OP_ADD:  begin dec.alu_control = ALU_ADD; dec.needs_write = 1'b1; end
            OP_SUB:  begin dec.alu_control = ALU_SUB; dec.needs_write = 1'b1; end
            OP_AND:  begin dec.alu_control = ALU_AND; dec.needs_write = 1'b1; end
            OP_OR:   begin dec.alu_control = ALU_OR;  dec.needs_write = 1'b1; end
            OP_SLT:  begin dec.alu_control = ALU_SLT; dec.needs_write = 1'b1; end
            OP_BEQ:  begin dec.alu_control = ALU_SUB; dec.is_branch   = 1'b1; end
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.is_nop = 1'b1;
        endcase
    end
endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the register-file/ALU datapath.
// Accepts an instruction in IDLE, then walks DECODE -> EXECUTE -> WRITEBACK
// (shortened for NOP, BEQ and HALT) while driving registered datapath
// controls, and counts retired instructions.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : slave side of datapath_sequencer_if
// Every output except instr_ready is registered. Output registers are loaded
// from the next-state decision, so each value is visible during the state it
// belongs to (addresses during DECODE, regwrite during WRITEBACK, the
// branch pulse during the IDLE cycle right after EXECUTE).
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    datapath_sequencer_if.slave bus
);
    state_t state, state_next;

    logic [INSTR_W-1:0]    instr_w;
    logic [2:0]            op_q, op_d;
    logic [2:0]            dec_op;
    dec_t                  dec;

    logic [REG_ADDR_W-1:0] rd1_q, rd1_d;
    logic [REG_ADDR_W-1:0] rd2_q, rd2_d;
    logic [REG_ADDR_W-1:0] wr_q, wr_d;
    logic [2:0]            alu_q, alu_d;
    logic                  regwrite_q, regwrite_d;
    logic                  branch_q, branch_d;
    logic                  halted_q, halted_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign instr_w = bus.instr;

    // In IDLE the decoder looks at the word being offered so alu_control can
    // be loaded on the accepting edge; afterwards it looks at the latched op.
    assign dec_op = (state == S_IDLE) ? instr_w[OPC_LSB +: 3] : op_q;

    seq_decode u_decode (
        .opcode (dec_op),
        .dec    (dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_NOP;
            rd1_q      <= '0;
            rd2_q      <= '0;
            wr_q       <= '0;
            alu_q      <= ALU_ADD;
            regwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_next;
            op_q       <= op_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            wr_q       <= wr_d;
            alu_q      <= alu_d;
            regwrite_q <= regwrite_d;
            branch_q   <= branch_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_next = state;
        op_d       = op_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        wr_d       = wr_q;
        alu_d      = alu_q;
        regwrite_d = 1'b0;   // single-cycle pulses default low
        branch_d   = 1'b0;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        case (state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    state_next = S_DECODE;
                    op_d       = instr_w[OPC_LSB +: 3];
                    rd1_d      = instr_w[RS1_LSB +: REG_ADDR_W];
                    rd2_d      = instr_w[RS2_LSB +: REG_ADDR_W];
                    wr_d       = instr_w[RD_LSB  +: REG_ADDR_W];
                    alu_d      = dec.alu_control;
                end
            end
            S_DECODE: begin
                if (dec.is_nop) begin
                    state_next = S_IDLE;
                    cnt_d      = cnt_q + CNT_W'(1);
                end else if (dec.is_halt) begin
                    state_next = S_HALTED;
                    halted_d   = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (dec.is_branch) begin
                    // zero_flag is the compare result of this EXECUTE cycle
                    state_next = S_IDLE;
                    branch_d   = bus.zero_flag;
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    state_next = S_WRITEBACK;
                    regwrite_d = dec.needs_write;
                end
            end
            S_WRITEBACK: begin
                state_next = S_IDLE;
                cnt_d      = cnt_q + CNT_W'(1);
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.instr_ready   = (state == S_IDLE) && !reset;
    assign bus.read_reg_num1 = rd1_q;
    assign bus.read_reg_num2 = rd2_q;
    assign bus.write_reg     = wr_q;
    assign bus.alu_control   = alu_q;
    assign bus.regwrite      = regwrite_q;
    assign bus.branch_taken  = branch_q;
    assign bus.halted        = halted_q;
    assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: a vector table of single
// instructions with expected controls, latency and pulse counts (expected
// records queued at drive time, popped on retirement), plus hand sequences
// for streaming, HALT, reset mid-instruction and counter wrap.
module tb_datapath_sequencer;
    import datapath_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    datapath_sequencer_if bus ();

    datapath_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [11:0] instr;
        logic       zf;
        logic       chk_alu;
        logic [2:0] alu;
        logic [1:0] rd1;
        logic [1:0] rd2;
        logic [1:0] wr;
        int         rw;
        int         br;
        int         lat;
    } vec_t;

    vec_t vt[9];
    vec_t sb_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    // Free-running monitors, sampled at the rising edge (pre-update values)
    int cyc       = 0;
    int rw_total  = 0;
    int rw_double = 0;
    logic rw_prev = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.regwrite === 1'b1) rw_total <= rw_total + 1;
        if (bus.regwrite === 1'b1 && rw_prev === 1'b1) rw_double <= rw_double + 1;
        rw_prev <= bus.regwrite;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [11:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    task automatic poll_ready(output bit ok);
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        ok = (bus.instr_ready === 1'b1);
    endtask

    task automatic wait_ready(input string tag);
        bit ok;
        poll_ready(ok);
        chk({tag, "_ready"}, 32'(ok), 32'd1);
    endtask

    // Drive one instruction, observe it to completion, score it.
    task automatic run_vec(input vec_t v);
        vec_t e;
        logic [7:0] cnt0;
        int c, rwn, brn;
        wait_ready(v.name);
        bus.instr       = v.instr;
        bus.instr_valid = 1'b1;
        bus.zero_flag   = v.zf;
        cnt0            = bus.retired_count;
        sb_q.push_back(v);
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        chk({v.name, "_rd1"}, 32'(bus.read_reg_num1), 32'(v.rd1));
        chk({v.name, "_rd2"}, 32'(bus.read_reg_num2), 32'(v.rd2));
        chk({v.name, "_wr"},  32'(bus.write_reg),     32'(v.wr));
        if (v.chk_alu) chk({v.name, "_alu"}, 32'(bus.alu_control), 32'(v.alu));
        c   = 1;
        rwn = (bus.regwrite === 1'b1) ? 1 : 0;
        brn = (bus.branch_taken === 1'b1) ? 1 : 0;
        while (bus.instr_ready !== 1'b1 && c < 20) begin
            @(negedge clock);
            c++;
            if (bus.regwrite === 1'b1) rwn++;
            if (bus.branch_taken === 1'b1) brn++;
        end
        e = sb_q.pop_front();
        chk({e.name, "_latency"},  32'(c),   32'(e.lat));
        chk({e.name, "_regwrite"}, 32'(rwn), 32'(e.rw));
        chk({e.name, "_branch"},   32'(brn), 32'(e.br));
        chk({e.name, "_retired"},  32'(bus.retired_count), 32'(cnt0 + 8'd1));
        bus.zero_flag = 1'b0;
    endtask

    initial begin : main
        logic [11:0] stream[4];
        logic [2:0]  s_alu[4];
        int          s_lat[3];
        int          acc[4];
        int          rw0, seen;
        logic [7:0]  cnt0;
        bit          ok;

        vt[0] = '{"add",     mk(OP_ADD, 2'd2, 2'd0, 2'd1), 1'b0, 1'b1, 3'b010, 2'd0, 2'd1, 2'd2, 1, 0, 4};
        vt[1] = '{"sub",     mk(OP_SUB, 2'd3, 2'd2, 2'd1), 1'b0, 1'b1, 3'b110, 2'd2, 2'd1, 2'd3, 1, 0, 4};
        vt[2] = '{"and",     mk(OP_AND, 2'd1, 2'd3, 2'd3), 1'b0, 1'b1, 3'b000, 2'd3, 2'd3, 2'd1, 1, 0, 4};
        vt[3] = '{"or",      mk(OP_OR,  2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 3'b001, 2'd1, 2'd2, 2'd0, 1, 0, 4};
        vt[4] = '{"slt",     mk(OP_SLT, 2'd3, 2'd0, 2'd3), 1'b0, 1'b1, 3'b111, 2'd0, 2'd3, 2'd3, 1, 0, 4};
        vt[5] = '{"beq_eq",  mk(OP_BEQ, 2'd0, 2'd1, 2'd1), 1'b1, 1'b1, 3'b110, 2'd1, 2'd1, 2'd0, 0, 1, 3};
        vt[6] = '{"beq_ne",  mk(OP_BEQ, 2'd2, 2'd1, 2'd2), 1'b0, 1'b1, 3'b110, 2'd1, 2'd2, 2'd2, 0, 0, 3};
        vt[7] = '{"nop",     mk(OP_NOP, 2'd1, 2'd2, 2'd3), 1'b0, 1'b0, 3'b010, 2'd2, 2'd3, 2'd1, 0, 0, 2};
        vt[8] = '{"add_lsb", mk(OP_ADD, 2'd1, 2'd2, 2'd3) | 12'h005, 1'b0, 1'b1, 3'b010, 2'd2, 2'd3, 2'd1, 1, 0, 4};

        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.zero_flag   = 1'b0;

        // Reset for two cycles, release, then look at the idle state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready",    32'(bus.instr_ready),   32'd1);
        chk("rst_alu",      32'(bus.alu_control),   32'h2);
        chk("rst_regwrite", 32'(bus.regwrite),      32'd0);
        chk("rst_retired",  32'(bus.retired_count), 32'd0);
        chk("rst_halted",   32'(bus.halted),        32'd0);
        chk("rst_branch",   32'(bus.branch_taken),  32'd0);
        chk("rst_addrs",    32'({bus.read_reg_num1, bus.read_reg_num2, bus.write_reg}), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Stream ADD, SUB, NOP, SLT with valid held high
        stream[0] = mk(OP_ADD, 2'd1, 2'd2, 2'd3);
        stream[1] = mk(OP_SUB, 2'd2, 2'd3, 2'd0);
        stream[2] = mk(OP_NOP, 2'd0, 2'd0, 2'd0);
        stream[3] = mk(OP_SLT, 2'd3, 2'd1, 2'd2);
        s_alu[0] = 3'b010; s_alu[1] = 3'b110; s_alu[2] = 3'b000; s_alu[3] = 3'b111;
        s_lat[0] = 4; s_lat[1] = 4; s_lat[2] = 2;
        wait_ready("stream_start");
        cnt0 = bus.retired_count;
        rw0  = rw_total;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.instr = stream[i];
            poll_ready(ok);
            acc[i] = cyc;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("stream%0d_accepted", i), 32'(bus.instr_ready), 32'd0);
            if (i != 2) chk($sformatf("stream%0d_alu", i), 32'(bus.alu_control), 32'(s_alu[i]));
        end
        bus.instr_valid = 1'b0;
        wait_ready("stream_end");
        for (int i = 0; i < 3; i++)
            chk($sformatf("stream_gap%0d", i), 32'(acc[i+1] - acc[i]), 32'(s_lat[i]));
        chk("stream_retired",  32'(bus.retired_count - cnt0), 32'd4);
        chk("stream_regwrite", 32'(rw_total - rw0), 32'd3);

        // HALT, then a valid ADD that must never be taken
        wait_ready("halt");
        cnt0 = bus.retired_count;
        bus.instr       = mk(OP_HALT, 2'd0, 2'd0, 2'd0);
        bus.instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.instr = mk(OP_ADD, 2'd3, 2'd1, 2'd1);
        rw0  = rw_total;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.instr_ready === 1'b1) seen++;
        end
        chk("halt_halted",   32'(bus.halted), 32'd1);
        chk("halt_ready",    32'(seen), 32'd0);
        chk("halt_regwrite", 32'(rw_total - rw0), 32'd0);
        chk("halt_retired",  32'(bus.retired_count), 32'(cnt0 + 8'd1));
        // Reset with valid still high: reset wins over the handshake
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus.instr_valid = 1'b0;
        #1;
        chk("halt_rst_halted",  32'(bus.halted), 32'd0);
        chk("halt_rst_ready",   32'(bus.instr_ready), 32'd1);
        chk("halt_rst_retired", 32'(bus.retired_count), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("halt_rst_idle", 32'(bus.instr_ready), 32'd1);

        // Reset during EXECUTE of SUB
        wait_ready("rst_exec");
        bus.instr       = mk(OP_SUB, 2'd3, 2'd2, 2'd1);
        bus.instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        rw0   = rw_total;
        @(posedge clock);
        @(negedge clock);
        chk("rexec_regwrite", 32'(bus.regwrite), 32'd0);
        chk("rexec_addrs",    32'({bus.read_reg_num1, bus.read_reg_num2, bus.write_reg}), 32'd0);
        chk("rexec_alu",      32'(bus.alu_control), 32'h2);
        chk("rexec_retired",  32'(bus.retired_count), 32'd0);
        chk("rexec_ready_in_reset", 32'(bus.instr_ready), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rexec_no_write", 32'(rw_total - rw0), 32'd0);
        chk("rexec_ready",    32'(bus.instr_ready), 32'd1);

        // 256 NOPs: counter reaches 255 then wraps to 0
        bus.instr       = mk(OP_NOP, 2'd0, 2'd0, 2'd0);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            poll_ready(ok);
            if (!ok) begin
                chk("wrap_ready", 32'd0, 32'd1);
                break;
            end
            if (i == 255) chk("wrap_255", 32'(bus.retired_count), 32'd255);
            @(posedge clock);
            @(negedge clock);
        end
        bus.instr_valid = 1'b0;
        wait_ready("wrap_end");
        chk("wrap_zero", 32'(bus.retired_count), 32'd0);

        chk("regwrite_single_cycle", 32'(rw_double), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control sequencer that drives the register-file/ALU datapath from the control side. It accepts 12-bit instruction words over a valid/ready handshake and decodes each one. It then sequences DECODE/EXECUTE/WRITEBACK, driving the register read addresses, write address, ALU control and regwrite, and sampling zero_flag for compare-branch instructions. It sits between the instruction source and the datapath and counts retired instructions.

Parameters:
INSTR_W, 12, instruction word width; field positions below assume 12
REG_ADDR_W, 2, register address width (4 registers)
CNT_W, 8, retired-instruction counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr  input  INSTR_W  instruction word: [11:9] opcode, [8:7] rd, [6:5] rs1, [4:3] rs2, [2:0] ignored
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  sequencer can accept an instruction
zero_flag  input  1  ALU zero result from datapath
read_reg_num1  output  REG_ADDR_W  datapath read port 1 address (rs1)
read_reg_num2  output  REG_ADDR_W  datapath read port 2 address (rs2)
write_reg  output  REG_ADDR_W  datapath write address (rd)
alu_control  output  3  ALU operation select
regwrite  output  1  datapath register write enable
branch_taken  output  1  one-cycle pulse: BEQ compared equal
halted  output  1  HALT executed; sticky until reset
retired_count  output  CNT_W  instructions retired, wraps

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values:
  - state IDLE
  - read_reg_num1/2 = 0, write_reg = 0
  - alu_control = 3'b010 (ADD)
  - regwrite = 0, branch_taken = 0, halted = 0, retired_count = 0
- All outputs are registered except instr_ready = (state==IDLE) && !reset.
- Opcodes and ALU codes:
  - 000 NOP
  - 001 ADD → 010
  - 010 SUB → 110
  - 011 AND → 000
  - 100 OR → 001
  - 101 SLT → 111
  - 110 BEQ → 110, no write
  - 111 HALT
- Handshake: transfer occurs on an edge where instr_valid && instr_ready. The instruction is latched internally and state goes to DECODE. instr_valid while not ready is ignored; the source must hold it.
- DECODE (1 cycle):
  - read_reg_num1 = rs1, read_reg_num2 = rs2, write_reg = rd, alu_control per opcode.
  - NOP → IDLE, retire.
  - HALT → HALTED, retire, halted=1.
  - All others → EXECUTE.
- EXECUTE (1 cycle): addresses and alu_control held.
  - ALU ops → WRITEBACK.
  - BEQ: zero_flag sampled at the end of EXECUTE. If 1, branch_taken=1 for exactly the next cycle. → IDLE, retire.
- WRITEBACK (1 cycle): regwrite=1 for exactly this cycle with addresses and alu_control held; the write lands on the closing edge. → IDLE, retire.
- Latency from the accepting edge to instr_ready high again:
  - ALU op: 4 cycles
  - BEQ: 3 cycles
  - NOP: 2 cycles
- Back-to-back: an instruction presented with valid held is accepted on the first IDLE edge. There are no idle bubbles beyond the IDLE cycle itself.
- regwrite is 0 in every state except WRITEBACK. It is never asserted for NOP, BEQ or HALT.
- HALTED: instr_ready=0 and outputs hold. Only reset leaves HALTED.
- retired_count: increments by 1 per retired instruction, including HALT. Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-instruction: the next edge returns to IDLE with reset values. Any in-flight instruction is discarded and no regwrite is issued.
- Reset has priority over a simultaneous handshake.

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP..OP_HALT)
  - ALU control constants (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111)
  - state encoding (IDLE, DECODE, EXECUTE, WRITEBACK, HALTED)
  - instruction field bit positions
- One natural sub-module, seq_decode: combinational opcode → {alu_control, needs_write, is_branch, is_halt, is_nop}. The FSM and registers stay in the top level.

Test Plan:
- Reset held 2 cycles, then released → instr_ready=1, alu_control=010, regwrite=0, retired_count=0, halted=0.
- ADD rd=2, rs1=0, rs2=1 (instr=12'b001_10_00_01_000) accepted at edge T:
  - T+1: read_reg_num1=0, read_reg_num2=1, write_reg=2, alu_control=010.
  - T+3: regwrite=1 for exactly 1 cycle.
  - T+4: instr_ready=1, retired_count=1.
- BEQ rs1=1, rs2=1 with zero_flag driven 1 during EXECUTE → alu_control=110, regwrite never 1, branch_taken pulses 1 cycle. Repeat with zero_flag=0 → no pulse.
- Stream ADD, SUB, NOP, SLT with instr_valid held high:
  - each accepted on the first IDLE edge, with correct alu_control sequence 010, 110, –, 111;
  - retired_count=4;
  - exactly 3 regwrite pulses.
- HALT then a valid ADD → halted=1, instr_ready stays 0, no regwrite; reset returns to IDLE with halted=0.
- Reset asserted during the EXECUTE of SUB → no regwrite pulse, all outputs at reset values next cycle, retired_count=0. Separately, 256 NOPs → retired_count wraps to 0.
